uart_rxq: RTL
=============

Name: uart_rxq

Overview:
- Parametrised receive queue for the 16550-class UART; sits between the rx deserialiser and the register file.
- Generalises the plain rx FIFO in width and depth.
- Adds per-entry error status (PE/FE/BI), a selectable trigger level, a sticky overrun flag, a FIFO-error summary and the 16550 character-timeout indication.

Parameters:
- DW, 8: data width per entry, in bits.
- DEPTH, 16: queue depth; power of two, at least 4.
- TO_CHARS, 4: character times of inactivity before timeout asserts.
- CW, $clog2(DEPTH+1): width of the count outputs.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- en  in  1  FIFO mode (FCR.ena); 0 = single-entry holding register
- clr  in  1  flush pulse (FCR rx reset)
- baud_pulse  in  1  16x baud tick
- frame_bits  in  4  bits per frame: start + data + parity + stop
- push  in  1  write strobe from the deserialiser
- din  in  DW  received data
- err_in  in  3  {bi, fe, pe} for din
- pop  in  1  RBR read strobe
- lsr_rd  in  1  LSR read strobe; clears overrun
- trig_sel  in  2  trigger select: 0→1, 1→DEPTH/4, 2→DEPTH/2, 3→DEPTH-2
- dout  out  DW  head entry data
- err_out  out  3  head entry error bits
- count  out  CW  occupancy
- empty  out  1  count == 0
- full  out  1  count == capacity (DEPTH if en=1, else 1)
- overrun  out  1  sticky overrun (LSR.OE)
- fifo_err  out  1  at least one queued entry has a nonzero err field (LSR bit 7)
- trig  out  1  trigger level reached
- timeout  out  1  character timeout

Behaviour:
- Reset (rst=0 at a clk edge):
  - All outputs clear to 0, except empty=1.
  - Pointers, counters and memory-valid state clear.
  - Reset overrides every other input in that cycle.
- Storage and read-out:
  - Circular buffer of {err_in, din}.
  - First-word-fall-through: dout and err_out combinationally reflect the head entry.
  - Head is valid the cycle after a push into an empty queue.
  - dout and err_out read 0 while empty.
- Push:
  - Accepted when not full: entry written, count+1 next cycle.
  - When full with no pop: entry dropped, stored data untouched, overrun=1 next cycle.
- Pop:
  - Accepted when not empty: head advances, count-1.
  - When empty: ignored, no state change.
- Simultaneous push and pop:
  - Not empty: both occur, count unchanged; this holds when full too, so no overrun.
  - Empty: push only.
- Pointer wrap: pointers wrap modulo DEPTH. In non-FIFO mode only slot 0 is used.
- Overrun clearing:
  - Cleared by lsr_rd on the following edge.
  - If lsr_rd coincides with a new overrun event, overrun stays 1.
  - Not cleared by clr or by a change of en.
- Flush:
  - Triggered by clr=1, or any change of en (en registered; mismatch = flush).
  - Empties the queue next cycle and zeroes the error-entry counter and timeout state.
  - A push in the flush cycle is discarded.
- fifo_err: tracks an error-entry counter (+1 on accepted push with err_in≠0, −1 on accepted pop with head err≠0); fifo_err = counter≠0.
- trig:
  - en=1: trig = count ≥ level(trig_sel).
  - en=0: trig = !empty.
  - Combinational from the count register.
- Timeout:
  - Baud-tick counter cleared on any accepted push or pop, on flush, and while empty.
  - Otherwise increments on each baud_pulse.
  - When it reaches TO_CHARS·16·frame_bits (compare width sized for frame_bits=15), timeout=1; the counter saturates.
  - Timeout holds until the next accepted push or pop, or a flush.
  - Only active when en=1; 0 otherwise.
  - A frame_bits change takes effect at the next comparison.

Optional Feature:
- UART_RXQ_PEAK_EN defined:
  - Adds output peak [CW], the highest count since reset or the last lsr_rd.
  - Updated each cycle to max(peak, count) after that cycle's update; lsr_rd loads the current count.
  - Flush does not clear peak.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package uart_pkg:
  - rx_err_t packed struct {bi, fe, pe}
  - trigger-select enum
  - localparam TO_CHARS_DEF = 4
  - Function trig_level(sel, depth).
- One sub-module is natural: uart_rxq_tmo (baud-tick timeout counter, inputs clear/active/frame_bits, output timeout). The queue stays inline.

Test Plan:
- Reset: hold rst=0 for 2 cycles mid-traffic → empty=1, count=0, overrun=0, timeout=0.
- FIFO mode, trig_sel=2: push 0x11..0x18 → trig=1 exactly at count=8; pops return 0x11..0x18 in order with err_out=0.
- Overrun: fill 16, push 0xAA → overrun=1, last head still 0x11. Push+pop on the full queue in one cycle → count stays 16, no new overrun. lsr_rd → overrun=0.
- Errors: push 0x55 with err_in=3'b010 among clean entries → fifo_err=1 until that entry is popped; err_out=3'b010 when it is at the head.
- Timeout: frame_bits=10, one entry queued, 639 baud_pulses → timeout=0; 640th → timeout=1; pop → timeout=0.
- Mode change: 5 entries queued, en 1→0 → count=0 next cycle, full after a single push, trig=!empty, overrun preserved.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: per-entry receive error status, rx trigger selection and
// the trigger-level helper used by the receive queue.
package uart_pkg;

    localparam int unsigned TO_CHARS_DEF = 32'd4;

    typedef struct packed {
        logic bi;
        logic fe;
        logic pe;
    } rx_err_t;

    typedef enum logic [1:0] {
        TRIG_ONE       = 2'd0,
        TRIG_QUARTER   = 2'd1,
        TRIG_HALF      = 2'd2,
        TRIG_NEAR_FULL = 2'd3
    } trig_sel_t;

    function automatic int unsigned trig_level(input trig_sel_t sel, input int unsigned depth);
        int unsigned lvl;
        case (sel)
            TRIG_ONE:       lvl = 32'd1;
            TRIG_QUARTER:   lvl = depth / 32'd4;
            TRIG_HALF:      lvl = depth / 32'd2;
            TRIG_NEAR_FULL: lvl = depth - 32'd2;
            default:        lvl = 32'd1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_rxq_tmo.sv
// Character-timeout counter: counts 16x baud ticks of queue inactivity and
// raises timeout after TO_CHARS character times of frame_bits bits each.
module uart_rxq_tmo
    import uart_pkg::*;
#(
    parameter int unsigned TO_CHARS = TO_CHARS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       active,
    input  logic       baud_pulse,
    input  logic [3:0] frame_bits,
    output logic       timeout
);

    // Sized for the longest frame so any frame_bits setting fits the compare
    localparam int unsigned TW = $clog2(TO_CHARS * 32'd16 * 32'd15 + 32'd1);

    logic [TW-1:0] cnt_r;
    logic [TW-1:0] cnt_nxt_s;
    logic [TW-1:0] limit_s;
    logic          tmo_r;

    assign limit_s = TW'(TO_CHARS) * TW'({frame_bits, 4'b0000});

    // Next tick count: clear, saturate at the limit, else count baud ticks
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clear || !active) begin
            cnt_nxt_s = {TW{1'b0}};
        end else if (baud_pulse && (cnt_r < limit_s)) begin
            cnt_nxt_s = cnt_r + TW'(1'b1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and timeout flag registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {TW{1'b0}};
            tmo_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            tmo_r <= active && !clear && (cnt_nxt_s >= limit_s);
        end
    end

    assign timeout = tmo_r;

endmodule

// File: rtl/uart_rxq.sv
// 16550-class receive queue with per-entry error status, trigger level,
// sticky overrun and character timeout. UART_RXQ_PEAK_EN adds a peak output.
module uart_rxq
    import uart_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TO_CHARS = TO_CHARS_DEF,
    parameter int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          baud_pulse,
    input  logic [3:0]    frame_bits,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic [2:0]    err_in,
    input  logic          pop,
    input  logic          lsr_rd,
    input  logic [1:0]    trig_sel,
    output logic [DW-1:0] dout,
    output logic [2:0]    err_out,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          overrun,
    output logic          fifo_err,
    output logic          trig,
    output logic          timeout
`ifdef UART_RXQ_PEAK_EN
    ,
    output logic [CW-1:0] peak
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = DW + 3;

    logic [EW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wptr_r, rptr_r, wptr_nxt_s, rptr_nxt_s;
    logic [CW-1:0] count_r, count_nxt_s, errcnt_r, errcnt_nxt_s, cap_s;
    logic          en_r, overrun_r;
    logic          flush_s, empty_s, full_s, push_ok_s, pop_ok_s, ovr_evt_s;
    logic [EW-1:0] head_s;
    rx_err_t       in_err_s, head_err_s;

    // A change of mode flushes exactly like an explicit clear
    assign flush_s    = clr | (en ^ en_r);
    assign cap_s      = en_r ? CW'(DEPTH) : CW'(1'b1);
    assign empty_s    = (count_r == {CW{1'b0}});
    assign full_s     = (count_r == cap_s);
    assign head_s     = mem_r[rptr_r];
    assign head_err_s = rx_err_t'(head_s[EW-1:DW]);
    assign in_err_s   = rx_err_t'(err_in);

    assign pop_ok_s  = pop & ~empty_s & ~flush_s;
    assign push_ok_s = push & ~flush_s & (~full_s | pop_ok_s);
    assign ovr_evt_s = push & ~flush_s & full_s & ~pop_ok_s;

    // Next pointers, occupancy and error-entry count
    always_comb begin
        wptr_nxt_s   = wptr_r;
        rptr_nxt_s   = rptr_r;
        count_nxt_s  = count_r;
        errcnt_nxt_s = errcnt_r;
        if (flush_s) begin
            wptr_nxt_s   = {AW{1'b0}};
            rptr_nxt_s   = {AW{1'b0}};
            count_nxt_s  = {CW{1'b0}};
            errcnt_nxt_s = {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wptr_nxt_s = en_r ? (wptr_r + AW'(1'b1)) : {AW{1'b0}};
            end else begin
                wptr_nxt_s = wptr_r;
            end
            if (pop_ok_s) begin
                rptr_nxt_s = en_r ? (rptr_r + AW'(1'b1)) : {AW{1'b0}};
            end else begin
                rptr_nxt_s = rptr_r;
            end
            count_nxt_s  = count_r + CW'(push_ok_s) - CW'(pop_ok_s);
            errcnt_nxt_s = errcnt_r
                         + CW'(push_ok_s & (in_err_s.bi | in_err_s.fe | in_err_s.pe))
                         - CW'(pop_ok_s & (head_err_s.bi | head_err_s.fe | head_err_s.pe));
        end
    end

    // Entry storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (rst && push_ok_s) begin
            mem_r[wptr_r] <= {err_in, din};
        end
    end

    // Queue state and sticky overrun
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_r      <= 1'b0;
            wptr_r    <= {AW{1'b0}};
            rptr_r    <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            errcnt_r  <= {CW{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            en_r     <= en;
            wptr_r   <= wptr_nxt_s;
            rptr_r   <= rptr_nxt_s;
            count_r  <= count_nxt_s;
            errcnt_r <= errcnt_nxt_s;
            if (ovr_evt_s) begin
                overrun_r <= 1'b1;
            end else if (lsr_rd) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    // Trigger: level compare in FIFO mode, data-ready in holding mode
    always_comb begin
        trig = 1'b0;
        if (en_r) begin
            trig = (32'(count_r) >= trig_level(trig_sel_t'(trig_sel), DEPTH));
        end else begin
            trig = ~empty_s;
        end
    end

    uart_rxq_tmo #(
        .TO_CHARS(TO_CHARS)
    ) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .clear     (push_ok_s | pop_ok_s | flush_s | empty_s),
        .active    (en_r),
        .baud_pulse(baud_pulse),
        .frame_bits(frame_bits),
        .timeout   (timeout)
    );

    assign dout     = empty_s ? {DW{1'b0}} : head_s[DW-1:0];
    assign err_out  = empty_s ? 3'b000 : head_s[EW-1:DW];
    assign count    = count_r;
    assign empty    = empty_s;
    assign full     = full_s;
    assign overrun  = overrun_r;
    assign fifo_err = (errcnt_r != {CW{1'b0}});

`ifdef UART_RXQ_PEAK_EN
    logic [CW-1:0] peak_r;

    // High-water mark of occupancy; survives flushes, reloaded by LSR reads
    always_ff @(posedge clk) begin
        if (!rst) begin
            peak_r <= {CW{1'b0}};
        end else if (lsr_rd) begin
            peak_r <= count_r;
        end else if (count_nxt_s > peak_r) begin
            peak_r <= count_nxt_s;
        end else begin
            peak_r <= peak_r;
        end
    end

    assign peak = peak_r;
`endif

endmodule
